// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter
//
// Arbitrates two requesters onto the single CLINT register port.
// Requester 0 is the core LSU and requester 1 is the debug module.
// Every access follows a fixed IDLE -> ISSUE -> RESP sequence, which matches the
// CLINT's registered read path. Round-robin decides between the two when both are valid.
//
// Optional feature: define CLINT_ARB_LOCK_EN to enable the LOCKED state.
// In that state the owner can issue back-to-back accesses, e.g. a 64-bit mtimecmp update.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   mN_req_valid / mN_req_ready   request handshake (N = 0, 1)
//   mN_addr, mN_wdata, mN_we      request payload
//   mN_lock                       keep ownership after this access (lock build only)
//   mN_rsp_valid, mN_rdata        one-cycle response; rdata is 0 when not valid
//   clint_addr, clint_wdata       CLINT address / write data (held outside ISSUE)
//   clint_we                      CLINT write strobe, only during ISSUE
//   clint_rdata                   CLINT registered read data
module clint_bus_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rdata,
    output logic [31:0] clint_addr,
    output logic [31:0] clint_wdata,
    output logic        clint_we,
    input  logic [31:0] clint_rdata
);

`ifdef CLINT_ARB_LOCK_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StResp   = 2'd2,
        StLocked = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;
`endif

    state_e      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    logic        grant_vld;
    logic        grant_id;

`ifdef CLINT_ARB_LOCK_EN
    logic        lock_q, lock_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
`else
    logic        unused_lock_cfg;
    assign unused_lock_cfg = m0_lock ^ m1_lock ^ (LOCK_TIMEOUT != 0);
`endif

    // Grant selection. A grant always implies that the granted requester is valid,
    // so grant_vld doubles as the handshake strobe.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_vld = m0_req_valid | m1_req_valid;
                grant_id  = (m0_req_valid & m1_req_valid) ? rr_ptr_q : m1_req_valid;
            end
`ifdef CLINT_ARB_LOCK_EN
            StLocked: begin
                grant_vld = owner_q ? m1_req_valid : m0_req_valid;
                grant_id  = owner_q;
            end
`endif
            default: ;
        endcase
        // Nothing is accepted while reset is asserted.
        if (reset) begin
            grant_vld = 1'b0;
        end
    end

    assign m0_req_ready = grant_vld & ~grant_id;
    assign m1_req_ready = grant_vld & grant_id;

    // Next-state and capture logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
`ifdef CLINT_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
`endif
        if (grant_vld) begin
            owner_d = grant_id;
            addr_d  = grant_id ? m1_addr  : m0_addr;
            wdata_d = grant_id ? m1_wdata : m0_wdata;
            we_d    = grant_id ? m1_we    : m0_we;
`ifdef CLINT_ARB_LOCK_EN
            lock_d  = grant_id ? m1_lock  : m0_lock;
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    rr_ptr_d = ~grant_id;
                    state_d  = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp: begin
`ifdef CLINT_ARB_LOCK_EN
                if (lock_q) begin
                    // The timeout is measured from the RESP cycle, so RESP counts as 1.
                    state_d    = StLocked;
                    lock_cnt_d = 8'd1;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
`ifdef CLINT_ARB_LOCK_EN
            StLocked: begin
                if (grant_vld) begin
                    // Re-grants made under the lock leave rr_ptr unchanged.
                    state_d    = StIssue;
                    lock_cnt_d = 8'd0;
                end else if ({24'd0, lock_cnt_q} + 32'd1 >= LOCK_TIMEOUT) begin
                    state_d    = StIdle;
                    lock_d     = 1'b0;
                    lock_cnt_d = 8'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
`ifdef CLINT_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_cnt_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
`ifdef CLINT_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign clint_addr  = addr_q;
    assign clint_wdata = wdata_q;

    // The outputs are gated by reset. This suppresses a write, or a response, that
    // coincides with reset.
    always_comb begin
        clint_we     = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        m0_rdata     = 32'd0;
        m1_rdata     = 32'd0;
        if (!reset) begin
            if (state_q == StIssue) begin
                clint_we = we_q;
            end
            if (state_q == StResp) begin
                if (owner_q) begin
                    m1_rsp_valid = 1'b1;
                    m1_rdata     = clint_rdata;
                end else begin
                    m0_rsp_valid = 1'b1;
                    m0_rdata     = clint_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Scoreboard testbench for clint_bus_arbiter, with a small behavioural CLINT model.
// Each request task pushes the expected response (data and cycle) when its handshake occurs.
// A negedge monitor pops those entries and compares them against the DUT responses.
module tb_clint_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0, m0_lock = 1'b0, m1_lock = 1'b0;
    logic        m0_rsp_valid, m1_rsp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] clint_addr, clint_wdata, clint_rdata;
    logic        clint_we;

    always #5 clk = ~clk;

    clint_bus_arbiter #(.LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .clint_addr(clint_addr), .clint_wdata(clint_wdata), .clint_we(clint_we),
        .clint_rdata(clint_rdata)
    );

    // CLINT model: registered reads, writes committed at the edge; not reset by the DUT reset.
    logic        msip = 1'b0;
    logic [31:0] mtcmp_lo = 32'hFFFF_FFFF, mtcmp_hi = 32'hFFFF_FFFF;
    logic [63:0] mtime = 64'd0;
    initial clint_rdata = 32'd0;

    always @(posedge clk) begin
        mtime <= mtime + 64'd1;
        if (clint_we) begin
            case (clint_addr)
                32'h0200_0000: msip <= clint_wdata[0];
                32'h0200_4000: mtcmp_lo <= clint_wdata;
                32'h0200_4004: mtcmp_hi <= clint_wdata;
                default: ;
            endcase
        end
        case (clint_addr)
            32'h0200_0000: clint_rdata <= {31'd0, msip};
            32'h0200_4000: clint_rdata <= mtcmp_lo;
            32'h0200_4004: clint_rdata <= mtcmp_hi;
            32'h0200_BFF8: clint_rdata <= mtime[31:0];
            32'h0200_BFFC: clint_rdata <= mtime[63:32];
            default:       clint_rdata <= 32'd0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   grant_log[$];

    // Monitor: checks responses against the scoreboard, and checks that rdata is 0 when idle.
    always @(negedge clk) begin
        exp_t e;
        if (clint_we) we_count++;
        if (m0_rsp_valid) begin
            if (q0.size() == 0) chk("m0 unexpected response", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("m0 rdata", m0_rdata, e.data);
                chk("m0 response cycle", 32'(cyc), 32'(e.cyc));
            end
        end else chk("m0 rdata idle", m0_rdata, 32'd0);
        if (m1_rsp_valid) begin
            if (q1.size() == 0) chk("m1 unexpected response", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("m1 rdata", m1_rdata, e.data);
                chk("m1 response cycle", 32'(cyc), 32'(e.cyc));
            end
        end else chk("m1 rdata idle", m1_rdata, 32'd0);
    end

    // Issues one request. The caller is at posedge+#1, and the task returns at posedge+#1.
    task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic lk, input logic [31:0] exp_data,
                          output int hs);
        exp_t e;
        hs = -1;
        if (n == 0) begin
            m0_req_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_we = w; m0_lock = lk;
        end else begin
            m1_req_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_we = w; m1_lock = lk;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((n == 0 && m0_req_ready) || (n == 1 && m1_req_ready)) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            chk("handshake timeout", 32'd0, 32'd1);
        end else begin
            e.data = exp_data;
            e.cyc  = hs + 2;
            if (n == 0) q0.push_back(e); else q1.push_back(e);
            grant_log.push_back(n);
        end
        @(posedge clk);
        #1;
        if (n == 0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int h0, h1, h2, wc;
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};

        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset clint_addr", clint_addr, 32'd0);
        chk("reset clint_wdata", clint_wdata, 32'd0);
        chk("reset clint_we", {31'd0, clint_we}, 32'd0);
        chk("reset m0_rsp_valid", {31'd0, m0_rsp_valid}, 32'd0);
        chk("reset m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd0);
        chk("reset ready idle", {30'd0, m0_req_ready, m1_req_ready}, 32'd0);
        tick(1);

        // Single read of mtimecmp_lo after reset.
        wc = we_count;
        do_req(0, 32'h0200_4000, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, h0);
        tick(3);
        chk("read keeps clint_we low", 32'(we_count), 32'(wc));

        // Write msip followed by a read of msip.
        wc = we_count;
        do_req(0, 32'h0200_0000, 32'd1, 1'b1, 1'b0, 32'd0, h0);
        do_req(0, 32'h0200_0000, 32'd0, 1'b0, 1'b0, 32'd1, h1);
        chk("back-to-back spacing", 32'(h1 - h0), 32'd3);
        tick(3);
        chk("one write strobe", 32'(we_count), 32'(wc + 1));
        chk("msip written", {31'd0, msip}, 32'd1);

        // Unmapped address, through m1.
        do_req(1, 32'h0200_0008, 32'd0, 1'b0, 1'b0, 32'd0, h0);
        tick(3);

        // Contention in the first cycle after reset.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        grant_log.delete();
        fork
            do_req(0, 32'h0200_4000, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, h0);
            do_req(1, 32'h0200_4004, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, h1);
        join
        chk("contention m0 first", 32'(grant_log[0]), 32'd0);
        chk("contention m1 after 3", 32'(h1 - h0), 32'd3);
        tick(3);

        // Both requesters held valid: the grants alternate.
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++)
                do_req(0, 32'h0200_0000, 32'd0, 1'b0, 1'b0, 32'd1, h0);
            for (int j = 0; j < 3; j++)
                do_req(1, 32'h0200_4000, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, h1);
        join
        chk("alternation count", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk("alternation order", 32'(grant_log[k]), 32'(exp_order[k]));
        tick(3);

        // Reset lands in the ISSUE cycle of an m0 write of 0 to msip.
        wc = we_count;
        m0_req_valid = 1'b1; m0_addr = 32'h0200_0000; m0_wdata = 32'd0;
        m0_we = 1'b1; m0_lock = 1'b0;
        h0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_req_ready) begin h0 = cyc; break; end
        end
        chk("reset-test handshake", {31'd0, h0 >= 0}, 32'd1);
        @(posedge clk);
        #1;
        m0_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("clint_we on reset cycle", {31'd0, clint_we}, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(4);
        chk("reset suppresses write", 32'(we_count), 32'(wc));
        chk("msip retained", {31'd0, msip}, 32'd1);
        do_req(0, 32'h0200_0000, 32'd0, 1'b0, 1'b0, 32'd1, h0);
        tick(3);

`ifdef CLINT_ARB_LOCK_EN
        // Locked 64-bit mtimecmp update by m1, with m0 waiting.
        grant_log.delete();
        fork
            begin
                do_req(1, 32'h0200_4000, 32'h11, 1'b1, 1'b1, 32'hFFFF_FFFF, h1);
                do_req(1, 32'h0200_4004, 32'h22, 1'b1, 1'b0, 32'hFFFF_FFFF, h2);
            end
            begin
                tick(1);
                do_req(0, 32'h0200_0000, 32'd0, 1'b0, 1'b0, 32'd1, h0);
            end
        join
        chk("lock order size", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            chk("lock order 0", 32'(grant_log[0]), 32'd1);
            chk("lock order 1", 32'(grant_log[1]), 32'd1);
            chk("lock order 2", 32'(grant_log[2]), 32'd0);
        end
        tick(3);
        do_req(0, 32'h0200_4000, 32'd0, 1'b0, 1'b0, 32'h11, h0);
        do_req(0, 32'h0200_4004, 32'd0, 1'b0, 1'b0, 32'h22, h0);
        tick(3);

        // m1 takes the lock and then goes idle; m0 is admitted when the lock times out.
        fork
            do_req(1, 32'h0200_0000, 32'd0, 1'b0, 1'b1, 32'd1, h1);
            begin
                tick(1);
                do_req(0, 32'h0200_0000, 32'd0, 1'b0, 1'b0, 32'd1, h0);
            end
        join
        chk("lock timeout grant", 32'(h0 - h1), 32'd18);
        tick(3);
`endif

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
        chk("m0 responses drained", 32'(q0.size()), 32'd0);
        chk("m1 responses drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_bus_arbiter.md
# clint_bus_arbiter

Arbitrates two memory-mapped requesters onto the single CLINT register port: requester 0 is the core load/store unit, requester 1 is the debug module. It serialises accesses through a fixed issue/response sequence matched to the CLINT's registered read path, with round-robin fairness. It optionally supports a lock that lets one requester complete a 64-bit `mtimecmp` update as two uninterrupted 32-bit writes.

## Interface
- `LOCK_TIMEOUT`, 16: maximum number of idle cycles a lock is held waiting for its owner (range 1..255).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req_valid` / `m1_req_valid`  in  1  request valid.
- `m0_req_ready` / `m1_req_ready`  out  1  request accepted this cycle when high together with valid.
- `m0_addr` / `m1_addr`  in  32  byte address (CLINT map: 0x0200_0000 msip, 0x0200_4000/4004 mtimecmp, 0x0200_BFF8/BFFC mtime).
- `m0_wdata` / `m1_wdata`  in  32  write data.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock` / `m1_lock`  in  1  request lock retention after this access.
- `m0_rsp_valid` / `m1_rsp_valid`  out  1  one-cycle response pulse.
- `m0_rdata` / `m1_rdata`  out  32  response data; valid only when the matching `rsp_valid` is high, 0 otherwise.
- `clint_addr`  out  32  CLINT address.
- `clint_wdata`  out  32  CLINT write data.
- `clint_we`  out  1  CLINT write enable.
- `clint_rdata`  in  32  CLINT registered read data.

## Operation
- States: IDLE, ISSUE, RESP, plus LOCKED when `CLINT_ARB_LOCK_EN` is defined.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester named by `rr_ptr`.
  - `mN_req_ready` is combinational: high only in IDLE (or in LOCKED for the owner) and only for the granted N.
  - On handshake, capture addr, wdata, we, lock and the owner id; set `rr_ptr` to the other requester; go to ISSUE.
- ISSUE:
  - Drive the captured addr and wdata.
  - `clint_we` = captured we for exactly this one cycle.
  - Next state is RESP.
- RESP:
  - Owner's `rsp_valid` = 1.
  - `rdata` = `clint_rdata`, which is the register value sampled at the end of ISSUE. For writes this is the pre-write value.
  - Next state is IDLE, or LOCKED if the lock was captured (macro only).
- `clint_addr` and `clint_wdata` hold their last values outside ISSUE. `clint_we` = 0 outside ISSUE.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal and cancels the request.
- Addresses are passed through unchecked. Unmapped CLINT addresses return 0.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0.
  - `clint_addr` = 0, `clint_wdata` = 0, `clint_we` = 0.
  - All `rsp_valid` = 0, all `rdata` = 0.
  - Lock state cleared.
- Handshake in cycle T gives ISSUE in T+1 (write committed at the T+1 edge), RESP in T+2, and the next acceptance no earlier than T+3. Throughput is one access per 3 cycles.
- The `mtime` value read reflects the count at the end of T+1.
- Requests arriving during ISSUE or RESP wait. No request is lost or reordered within a requester.
- Both requesters valid continuously: grants alternate 0, 1, 0, 1 …
- Reset asserted in any state: next cycle is IDLE with reset values. An in-flight access gets no response. A write is suppressed if reset coincides with ISSUE.

## Configuration
- `CLINT_ARB_LOCK_EN` defined:
  - A handshake with `lock` = 1 sends RESP to LOCKED, not IDLE.
  - In LOCKED, only the owner can be granted. The other requester's ready is held at 0.
  - An owner handshake in LOCKED proceeds to ISSUE with its new lock bit. A `lock` = 0 access releases the lock after its RESP.
  - A cycle counter increments each LOCKED cycle without an owner handshake. When it reaches `LOCK_TIMEOUT`, the block returns to IDLE and releases the lock.
  - `rr_ptr` is not updated by locked re-grants.
- `CLINT_ARB_LOCK_EN` undefined:
  - `mN_lock` inputs are ignored and no LOCKED state exists.
  - Ports remain present.

## Test plan
- Single read: m0 reads 0x0200_4000 after reset → `m0_rsp_valid` 2 cycles after handshake with `rdata` = 0xFFFF_FFFF. `clint_we` stays 0.
- Write then read: m0 writes 0x1 to 0x0200_0000 → its response carries `rdata` = 0 (old value). A following m0 read returns 0x1.
- Contention: m0 and m1 both valid at the cycle after reset with distinct addresses → m0 granted first, m1 3 cycles later. Held continuously, the grant order is 0, 1, 0, 1.
- Lock (macro on): m1 writes 0x0200_4000 with lock = 1 while m0 is valid. Then m1 writes 0x0200_4004 with lock = 0 → both m1 writes complete before any m0 grant, and `mtimecmp` is updated atomically.
- Lock timeout (macro on): m1 locks and then goes idle → m0 is granted exactly `LOCK_TIMEOUT` = 16 cycles after m1's RESP.
- Reset during ISSUE of an m0 write of 0x0 to 0x0200_0000 (msip previously 1) → no `m0_rsp_valid`, `clint_we` = 0 on the reset cycle, msip remains 1.
